// File: rtl/lut_debounce_n.sv
// Purpose: synchronize and debounce up to four raw pins, then drive a registered 4-input LUT result in level or toggle mode.
// Latency: a stable pin change reaches DB_OUT after DB_CYCLES+1 edges, and reaches LUT_Q/OUT/RISE one edge after that.
// Backpressure: none; the block is free-running and every stage updates on each CLK edge.
module lut_debounce_n #(
  parameter int          N_IN      = 2,
  parameter logic [15:0] LUT_INIT  = 16'h8888,
  parameter int          DB_CYCLES = 4,
  parameter int          OUT_MODE  = 0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N_IN-1:0] PIN_IN,
  output logic [N_IN-1:0] DB_OUT,
  output logic            LUT_Q,
  output logic            OUT,
  output logic            RISE
);

  localparam int               CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_IN-1:0]  sync1;
  logic [N_IN-1:0]  sync2;
  logic [CNT_W-1:0] cnt [N_IN];
  logic [3:0]       lut_idx;
  logic             lut_c;
  logic             lut_rise;

  // Two-flop synchronizer for the asynchronous pins
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= PIN_IN;
      sync2 <= sync1;
    end
  end

  // Per-channel debounce: a channel only flips after DB_CYCLES consecutive disagreeing samples
  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_IN; i++) begin
      if (!RST_N) begin
        cnt[i]    <= '0;
        DB_OUT[i] <= 1'b0;
      end else if (sync2[i] == DB_OUT[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == CNT_TERM) begin
        DB_OUT[i] <= sync2[i];
        cnt[i]    <= '0;
      end else begin
        cnt[i] <= cnt[i] + CNT_ONE;
      end
    end
  end

  // Unused LUT inputs read as 0, so only the low 2**N_IN table entries are ever selected
  always_comb begin
    lut_idx  = 4'(DB_OUT);
    lut_c    = LUT_INIT[lut_idx];
    lut_rise = lut_c & ~LUT_Q;
  end

  // Registered LUT result, its rising-edge pulse, and the mode-dependent output
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      LUT_Q <= 1'b0;
      RISE  <= 1'b0;
      OUT   <= 1'b0;
    end else begin
      LUT_Q <= lut_c;
      RISE  <= lut_rise;
      if (OUT_MODE == 0) begin
        OUT <= lut_c;
      end else begin
        OUT <= OUT ^ lut_rise;
      end
    end
  end

endmodule

// File: tb/tb_lut_debounce_n.sv
// Bench for lut_debounce_n: five differently configured instances share clock and reset.
// Directed scenarios use hand-derived constants; randomized traffic is checked against a window-based model.
// Inputs change just after the falling edge, and outputs are sampled on the falling edge.
module tb_lut_debounce_n;

  localparam int NI  = 5;
  localparam int WIN = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] pin [NI];

  always #5 clk = ~clk;

  wire [1:0] db0;
  wire [1:0] db1;
  wire [3:0] db2;
  wire [2:0] db3;
  wire [0:0] db4;
  wire [3:0] db_o [NI];
  wire [NI-1:0] lutq_o;
  wire [NI-1:0] out_o;
  wire [NI-1:0] rise_o;

  assign db_o[0] = {2'b00, db0};
  assign db_o[1] = {2'b00, db1};
  assign db_o[2] = db2;
  assign db_o[3] = {1'b0, db3};
  assign db_o[4] = {3'b000, db4};

  // 0: AND level, 1: AND toggle, 2: 4-bit parity DB1, 3: 3-input OR, 4: single-input inverter DB3
  lut_debounce_n #(.N_IN(2), .LUT_INIT(16'h8888), .DB_CYCLES(4), .OUT_MODE(0)) u_and (
    .CLK(clk), .RST_N(rst_n), .PIN_IN(pin[0][1:0]), .DB_OUT(db0),
    .LUT_Q(lutq_o[0]), .OUT(out_o[0]), .RISE(rise_o[0]));
  lut_debounce_n #(.N_IN(2), .LUT_INIT(16'h8888), .DB_CYCLES(4), .OUT_MODE(1)) u_tog (
    .CLK(clk), .RST_N(rst_n), .PIN_IN(pin[1][1:0]), .DB_OUT(db1),
    .LUT_Q(lutq_o[1]), .OUT(out_o[1]), .RISE(rise_o[1]));
  lut_debounce_n #(.N_IN(4), .LUT_INIT(16'h6996), .DB_CYCLES(1), .OUT_MODE(0)) u_par (
    .CLK(clk), .RST_N(rst_n), .PIN_IN(pin[2]), .DB_OUT(db2),
    .LUT_Q(lutq_o[2]), .OUT(out_o[2]), .RISE(rise_o[2]));
  lut_debounce_n #(.N_IN(3), .LUT_INIT(16'hFEFE), .DB_CYCLES(4), .OUT_MODE(0)) u_or (
    .CLK(clk), .RST_N(rst_n), .PIN_IN(pin[3][2:0]), .DB_OUT(db3),
    .LUT_Q(lutq_o[3]), .OUT(out_o[3]), .RISE(rise_o[3]));
  lut_debounce_n #(.N_IN(1), .LUT_INIT(16'hFFF1), .DB_CYCLES(3), .OUT_MODE(0)) u_inv (
    .CLK(clk), .RST_N(rst_n), .PIN_IN(pin[4][0:0]), .DB_OUT(db4),
    .LUT_Q(lutq_o[4]), .OUT(out_o[4]), .RISE(rise_o[4]));

  int n_total = 0;
  int n_bad   = 0;

  function automatic int cfg_n(int k);
    case (k)
      0, 1:    return 2;
      2:       return 4;
      3:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int cfg_db(int k);
    case (k)
      2:       return 1;
      4:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [15:0] cfg_lut(int k);
    case (k)
      0, 1:    return 16'h8888;
      2:       return 16'h6996;
      3:       return 16'hFEFE;
      default: return 16'hFFF1;
    endcase
  endfunction

  function automatic int cfg_mode(int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic logic [3:0] mask(int k);
    return 4'((1 << cfg_n(k)) - 1);
  endfunction

  // Reference model: pins pass through two delay stages; a debounced bit flips once the
  // most recent cfg_db samples since reset all disagree with it.
  logic [3:0] m_s1 [NI];
  logic [3:0] m_s2 [NI];
  logic [3:0] m_db [NI];
  logic [3:0] m_win [NI][WIN];
  int         m_len [NI];
  logic [NI-1:0] m_lutq;
  logic [NI-1:0] m_out;
  logic [NI-1:0] m_rise;

  function automatic logic [3:0] next_db(int k);
    logic [3:0] nd;
    logic [3:0] msk;
    int         dbc;
    logic       flip;
    nd  = m_db[k];
    msk = mask(k);
    dbc = cfg_db(k);
    for (int i = 0; i < 4; i++) begin
      if (msk[i]) begin
        flip = (m_s2[k][i] != m_db[k][i]) && (m_len[k] >= dbc - 1);
        for (int j = 0; j < dbc - 1; j++) begin
          if (m_win[k][j][i] == m_db[k][i]) flip = 1'b0;
        end
        if (flip) nd[i] = ~m_db[k][i];
      end
    end
    return nd;
  endfunction

  function automatic logic lut_of(int k);
    logic [15:0] tbl;
    logic [3:0]  idx;
    tbl = cfg_lut(k);
    idx = m_db[k] & mask(k);
    return tbl[idx];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        m_s1[k]   <= '0;
        m_s2[k]   <= '0;
        m_db[k]   <= '0;
        m_len[k]  <= 0;
        m_lutq[k] <= 1'b0;
        m_out[k]  <= 1'b0;
        m_rise[k] <= 1'b0;
      end else begin
        m_s1[k]   <= pin[k] & mask(k);
        m_s2[k]   <= m_s1[k];
        m_db[k]   <= next_db(k);
        m_lutq[k] <= lut_of(k);
        m_rise[k] <= lut_of(k) & ~m_lutq[k];
        m_out[k]  <= (cfg_mode(k) == 1) ? (m_out[k] ^ (lut_of(k) & ~m_lutq[k])) : lut_of(k);
        m_win[k][0] <= m_s2[k];
        for (int j = 1; j < WIN; j++) m_win[k][j] <= m_win[k][j-1];
        m_len[k]  <= (m_len[k] < WIN) ? m_len[k] + 1 : WIN;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) pin[k] = 4'($urandom);
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_total++;
      if ({db_o[k], lutq_o[k], out_o[k], rise_o[k]} !== 7'b0) begin
        n_bad++;
        $display("FAIL reset inst%0d: got db=%h q=%b out=%b rise=%b, want all 0",
                 k, db_o[k], lutq_o[k], out_o[k], rise_o[k]);
      end
    end
    for (int k = 0; k < NI; k++) pin[k] = 4'b0;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    // the inverter sees debounced 0 after reset, so its output settles high
    n_total++;
    if ({lutq_o[4], out_o[4], rise_o[4]} !== 3'b110) begin
      n_bad++;
      $display("FAIL reset_inv_idle: got q/out/rise=%b%b%b, want 110", lutq_o[4], out_o[4], rise_o[4]);
    end
  endtask

  task automatic test_and();
    logic [6:0] e;
    pin[0] = 4'b0011;
    for (int m = 0; m < 8; m++) begin
      @(negedge clk);
      e = {(m >= 5) ? 4'b0011 : 4'b0000, 1'(m >= 6), 1'(m >= 6), 1'(m == 6)};
      n_total++;
      if ({db_o[0], lutq_o[0], out_o[0], rise_o[0]} !== e) begin
        n_bad++;
        $display("FAIL and_rise m=%0d: got %b want %b", m, {db_o[0], lutq_o[0], out_o[0], rise_o[0]}, e);
      end
    end
    pin[0] = 4'b0010;
    for (int m = 0; m < 8; m++) begin
      @(negedge clk);
      e = {(m >= 5) ? 4'b0010 : 4'b0011, 1'(m < 6), 1'(m < 6), 1'b0};
      n_total++;
      if ({db_o[0], lutq_o[0], out_o[0], rise_o[0]} !== e) begin
        n_bad++;
        $display("FAIL and_fall m=%0d: got %b want %b", m, {db_o[0], lutq_o[0], out_o[0], rise_o[0]}, e);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] e;
    pin[0] = 4'b0000;
    repeat (10) @(negedge clk);
    pin[0] = 4'b0010;
    for (int m = 0; m < 12; m++) begin
      @(negedge clk);
      n_total++;
      if ({db_o[0], out_o[0], rise_o[0]} !== 6'b0) begin
        n_bad++;
        $display("FAIL glitch3 m=%0d: got db=%h out=%b rise=%b want 0", m, db_o[0], out_o[0], rise_o[0]);
      end
      if (m == 2) pin[0] = 4'b0000;
    end
    pin[0] = 4'b0010;
    for (int m = 0; m < 14; m++) begin
      @(negedge clk);
      e = (m >= 5 && m <= 8) ? 4'b0010 : 4'b0000;
      n_total++;
      if ({db_o[0], lutq_o[0], out_o[0], rise_o[0]} !== {e, 3'b000}) begin
        n_bad++;
        $display("FAIL glitch4 m=%0d: got db=%h q=%b out=%b rise=%b want db=%h rest 0",
                 m, db_o[0], lutq_o[0], out_o[0], rise_o[0], e);
      end
      if (m == 3) pin[0] = 4'b0000;
    end
  endtask

  task automatic test_toggle();
    logic tog;
    logic [2:0] e;
    tog = 1'b0;
    for (int p = 0; p < 6; p++) begin
      pin[1] = (p % 2 == 0) ? 4'b0011 : 4'b0000;
      for (int m = 0; m < 12; m++) begin
        @(negedge clk);
        if (p % 2 == 0) e = {1'(m >= 6), (m >= 6) ? ~tog : tog, 1'(m == 6)};
        else            e = {1'(m < 6), tog, 1'b0};
        n_total++;
        if ({lutq_o[1], out_o[1], rise_o[1]} !== e) begin
          n_bad++;
          $display("FAIL toggle p=%0d m=%0d: got q/out/rise=%b want %b", p, m, {lutq_o[1], out_o[1], rise_o[1]}, e);
        end
      end
      if (p % 2 == 0) tog = ~tog;
    end
  endtask

  task automatic test_parity();
    logic [3:0] prev;
    logic [4:0] e;
    prev = 4'b0000;
    for (int v = 0; v < 16; v++) begin
      pin[2] = 4'(v);
      for (int m = 0; m < 5; m++) begin
        @(negedge clk);
        e = {(m >= 2) ? 4'(v) : prev, (m >= 3) ? ^(4'(v)) : ^prev};
        n_total++;
        if ({db_o[2], lutq_o[2]} !== e) begin
          n_bad++;
          $display("FAIL parity v=%0d m=%0d: got db=%h q=%b want db=%h q=%b", v, m, db_o[2], lutq_o[2], e[4:1], e[0]);
        end
      end
      prev = 4'(v);
    end
  endtask

  task automatic test_channels();
    logic [6:0] e;
    pin[3] = 4'b0001;
    for (int m = 0; m < 11; m++) begin
      @(negedge clk);
      e = {1'b0, 1'(m >= 6), 1'b0, 1'(m >= 5), 1'(m >= 6), 1'(m >= 6), 1'(m == 6)};
      n_total++;
      if ({db_o[3], lutq_o[3], out_o[3], rise_o[3]} !== e) begin
        n_bad++;
        $display("FAIL channels m=%0d: got %b want %b", m, {db_o[3], lutq_o[3], out_o[3], rise_o[3]}, e);
      end
      if (m == 0) pin[3] = 4'b0101;
    end
  endtask

  task automatic test_single();
    logic [3:0] e;
    pin[4] = 4'b0001;
    for (int m = 0; m < 9; m++) begin
      @(negedge clk);
      e = {1'(m >= 4), 1'(m < 5), 1'(m < 5), 1'b0};
      n_total++;
      if ({db_o[4][0], lutq_o[4], out_o[4], rise_o[4]} !== e) begin
        n_bad++;
        $display("FAIL single_hi m=%0d: got %b want %b", m, {db_o[4][0], lutq_o[4], out_o[4], rise_o[4]}, e);
      end
    end
    pin[4] = 4'b0000;
    for (int m = 0; m < 9; m++) begin
      @(negedge clk);
      e = {1'(m < 4), 1'(m >= 5), 1'(m >= 5), 1'(m == 5)};
      n_total++;
      if ({db_o[4][0], lutq_o[4], out_o[4], rise_o[4]} !== e) begin
        n_bad++;
        $display("FAIL single_lo m=%0d: got %b want %b", m, {db_o[4][0], lutq_o[4], out_o[4], rise_o[4]}, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] e;
    pin[0] = 4'b0011;
    repeat (10) @(negedge clk);
    pin[0] = 4'b0000;
    repeat (4) @(negedge clk);
    n_total++;
    if ({db_o[0], out_o[0]} !== 5'b00111) begin
      n_bad++;
      $display("FAIL rstmid_pre: got db=%h out=%b want db=3 out=1", db_o[0], out_o[0]);
    end
    rst_n  = 1'b0;
    pin[0] = 4'b0011;
    @(negedge clk);
    n_total++;
    if ({db_o[0], lutq_o[0], out_o[0], rise_o[0]} !== 7'b0) begin
      n_bad++;
      $display("FAIL rstmid_clear: got %b want 0000000", {db_o[0], lutq_o[0], out_o[0], rise_o[0]});
    end
    rst_n = 1'b1;
    for (int m = 1; m < 10; m++) begin
      @(negedge clk);
      e = {(m >= 6) ? 4'b0011 : 4'b0000, 1'(m >= 7), 1'(m >= 7), 1'(m == 7)};
      n_total++;
      if ({db_o[0], lutq_o[0], out_o[0], rise_o[0]} !== e) begin
        n_bad++;
        $display("FAIL rstmid_requal m=%0d: got %b want %b", m, {db_o[0], lutq_o[0], out_o[0], rise_o[0]}, e);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        n_total++;
        if (db_o[k] !== m_db[k] || lutq_o[k] !== m_lutq[k] || out_o[k] !== m_out[k] || rise_o[k] !== m_rise[k]) begin
          n_bad++;
          if (n_bad <= 20)
            $display("FAIL random inst%0d cyc%0d: got db=%h q=%b out=%b rise=%b want db=%h q=%b out=%b rise=%b",
                     k, c, db_o[k], lutq_o[k], out_o[k], rise_o[k], m_db[k], m_lutq[k], m_out[k], m_rise[k]);
        end
      end
      for (int k = 0; k < NI; k++) begin
        if ($urandom_range(0, 5) == 0) pin[k] = 4'($urandom);
      end
      rst_n = ($urandom_range(0, 299) != 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) pin[k] = 4'b0;
    test_reset();
    test_and();
    test_glitch();
    test_toggle();
    test_parity();
    test_channels();
    test_single();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/lut_debounce_n.md
Name: lut_debounce_n

Overview:
- Parametrised successor to the single-LUT pin logic block on the hx1k board.
- Takes up to four raw input pins and passes each through a 2-FF synchronizer and a per-channel debounce counter.
- Evaluates a programmable 4-input truth table over the debounced vector and drives a registered output, in level or toggle mode.
- Sits between board input pins (SB_IO, PIN_TYPE 00_0000) and an LED/output pin.

Parameters:
- N_IN, 2: number of active inputs, legal range 1..4; LUT inputs I[N_IN..3] are tied to 0.
- LUT_INIT, 16'h8888: truth table. Output = LUT_INIT[{I3,I2,I1,I0}], with I0 = in[0].
- DB_CYCLES, 4: consecutive stable cycles required before a debounced input changes; legal range 1..65535.
- OUT_MODE, 0: 0 = level (out follows the LUT); 1 = toggle (out inverts on each rising edge of the LUT result).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  synchronous, active-low reset.
- PIN_IN  input  N_IN  raw, asynchronous input pins.
- DB_OUT  output  N_IN  debounced input vector.
- LUT_Q  output  1  registered LUT result; identical in both modes.
- OUT  output  1  final output to the LED pin.
- RISE  output  1  one-cycle pulse when LUT_Q goes 0->1.

Behaviour:
- Reset: while RST_N=0 at a CLK edge, the following all load 0: sync1, sync2, debounce counters, DB_OUT, LUT_Q, OUT, RISE. Reset has priority over all other updates.
- Reset mid-count discards partial debounce progress. The first post-reset evaluation uses DB_OUT=0.
- Synchronizer, per channel: sync1 <= PIN_IN[i]; sync2 <= sync1.
- Debounce, per channel. Counter width is clog2(DB_CYCLES+1).
  - If sync2 == DB_OUT[i]: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: DB_OUT[i] <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
- Any cycle where sync2 returns to DB_OUT[i] before the terminal count clears the counter. Glitches shorter than DB_CYCLES cycles never reach DB_OUT.
- Channels are fully independent; simultaneous changes on several channels update at the same edge if their counts complete together.
- LUT stage:
  - lut_c = LUT_INIT[idx], where idx = DB_OUT zero-extended to 4 bits. This is combinational from DB_OUT.
  - LUT_Q <= lut_c each edge.
  - RISE <= lut_c & ~LUT_Q.
- Output stage:
  - OUT_MODE=0: OUT <= lut_c, so OUT equals LUT_Q.
  - OUT_MODE=1: OUT <= OUT ^ (lut_c & ~LUT_Q). OUT toggles at the same edge RISE asserts and never toggles on falling LUT edges.
- Latency: PIN_IN changes and is held stable from before edge k. Then:
  - sync1 updates at edge k.
  - sync2 updates at edge k+1.
  - DB_OUT updates at edge k+DB_CYCLES+1.
  - LUT_Q, OUT and RISE update at edge k+DB_CYCLES+2.
- Boundaries:
  - DB_CYCLES=1 gives no extra filtering beyond one cycle.
  - Counters never wrap; they saturate only at DB_CYCLES-1.
  - N_IN=1 uses LUT_INIT[1:0] only.
  - A LUT whose result does not change for a given input change produces no RISE and no toggle.

Test Plan:
- AND, N_IN=2, LUT_INIT=16'h8888, DB_CYCLES=4, mode 0. PIN_IN 00->11 before edge 10 -> DB_OUT=11 at edge 15; LUT_Q=OUT=1 and RISE=1 for one cycle at edge 16. PIN_IN[0]->0 -> OUT=0 six edges later.
- Glitch rejection, same config. PIN_IN[1] high for 3 cycles, then low -> DB_OUT, OUT and RISE stay 0 throughout. A 4-cycle pulse -> DB_OUT[1] goes 1 for exactly 4 cycles.
- Toggle mode, OUT_MODE=1, same LUT. Three clean 11/00 cycles of PIN_IN -> OUT sequence 1,0,1. Each toggle coincides with a RISE pulse; there is no change on falling edges.
- Parity, N_IN=4, LUT_INIT=16'h6996, DB_CYCLES=1. Walk PIN_IN 0000..1111 holding each value for 5 cycles -> LUT_Q equals the XOR of the bits, 3 edges after each change.
- Reset mid-operation: assert RST_N=0 for 1 cycle while a counter is at 2 of 4 and OUT=1 -> all outputs are 0 on the next edge. Inputs still high -> DB_OUT re-qualifies DB_CYCLES+2 edges after reset release, and OUT returns to 1 one edge later.
- Independent channels, N_IN=3, LUT_INIT=16'hFEFE (OR). Change PIN_IN[0] and PIN_IN[2] one cycle apart -> DB_OUT bits update one edge apart. OUT rises on the first update only.
